// File: rtl/modexp_host_seq.sv
// Host-side sequencer for the ModExp core: buffers one operand from the host,
// replays it to ModExp, runs the compute, then captures and drains the result.
`ifndef DATA_WIDTH
`define DATA_WIDTH 128
`endif
`ifndef TERMINAL
`define TERMINAL 5'd16
`endif

module modexp_host_seq #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int NUM_WORDS  = 32,
  parameter int GAP_CYCLES = 2,
  parameter int RES_LAT    = 1,
  parameter int TIMEOUT    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  startInput,
  output logic                  startCompute,
  output logic                  getResult,
  output logic [DATA_WIDTH-1:0] inp,
  input  logic [DATA_WIDTH-1:0] outp,
  input  logic [4:0]            stateModExp,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_START, S_STREAM, S_GAP,
    S_COMPUTE, S_FETCH, S_CAPTURE, S_DRAIN
  } state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [31:0]           cnt;
  logic [DATA_WIDTH-1:0] opbuf  [NUM_WORDS];
  logic [DATA_WIDTH-1:0] resbuf [NUM_WORDS];
  logic                  in_fire;

  // Handshake: a word moves when valid and ready are both high at a rising edge.
  assign in_fire = in_valid & in_ready;

  // Buffers carry no reset; only the control state is cleared.
  always_ff @(posedge clk) begin
    if (in_fire) opbuf[idx] <= in_data;
    if (state == S_CAPTURE) resbuf[idx] <= outp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      cnt          <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      startInput   <= 1'b0;
      startCompute <= 1'b0;
      getResult    <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      inp          <= '0;
      out_data     <= '0;
    end else begin
      startInput <= 1'b0;
      case (state)
        S_IDLE, S_LOAD: begin
          if (in_fire) begin
            busy <= 1'b1;
            if (idx == '0) timeout_err <= 1'b0;
            if (idx == LAST) begin
              state      <= S_START;
              idx        <= '0;
              in_ready   <= 1'b0;
              startInput <= 1'b1;
            end else begin
              state <= S_LOAD;
              idx   <= idx + 1'b1;
            end
          end
        end
        S_START: begin
          state <= S_STREAM;
          idx   <= '0;
          inp   <= opbuf[0];
        end
        S_STREAM: begin
          if (idx == LAST) begin
            idx <= '0;
            cnt <= '0;
            if (GAP_CYCLES == 0) begin
              state        <= S_COMPUTE;
              startCompute <= 1'b1;
            end else begin
              state <= S_GAP;
            end
          end else begin
            idx <= idx + 1'b1;
            inp <= opbuf[idx + 1'b1];
          end
        end
        S_GAP: begin
          if (cnt == 32'(GAP_CYCLES - 1)) begin
            state        <= S_COMPUTE;
            startCompute <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_COMPUTE: begin
          // TERMINAL takes priority over a watchdog expiry in the same cycle.
          if (stateModExp == `TERMINAL) begin
            startCompute <= 1'b0;
            getResult    <= 1'b1;
            cnt          <= '0;
            idx          <= '0;
            state        <= (RES_LAT == 0) ? S_CAPTURE : S_FETCH;
          end else if (TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1)) begin
            startCompute <= 1'b0;
            timeout_err  <= 1'b1;
            busy         <= 1'b0;
            in_ready     <= 1'b1;
            cnt          <= '0;
            state        <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FETCH: begin
          if (cnt == 32'(RES_LAT - 1)) begin
            state <= S_CAPTURE;
            idx   <= '0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          if (idx == LAST) begin
            state     <= S_DRAIN;
            idx       <= '0;
            getResult <= 1'b0;
            out_valid <= 1'b1;
            // With a single-word result, word 0 is still on outp this cycle.
            out_data  <= (idx == '0) ? outp : resbuf[0];
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (idx == LAST) begin
              state     <= S_IDLE;
              idx       <= '0;
              out_valid <= 1'b0;
              out_data  <= '0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              idx      <= idx + 1'b1;
              out_data <= resbuf[idx + 1'b1];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
